vlg_design: RTL and testbench
=============================

Name: vlg_design

Overview:
- Parameterised binary-to-Gray-code encoder with a single registered output stage and a valid flag.
- Sits in a datapath wherever a binary count or value must be Gray-coded, for example before a clock-domain crossing.
- One input word is accepted per enabled clock. The encoded word appears one clock later, qualified by o_vld.

Parameters:
- MSB, default 7: index of the most significant data bit. Data width is MSB+1 bits. Legal values are 0 and above.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-high.
- i_en  input  1  input-valid/enable; i_data is sampled when i_en is 1.
- i_data  input  MSB+1  binary input word.
- o_vld  output  1  high for one cycle per accepted input; qualifies o_gray.
- o_gray  output  MSB+1  registered Gray code of the accepted i_data.

Behaviour:
- Interface: reset rst_n, asynchronous, active-high; clock clk.
- Reset: while rst_n is 1, o_vld=0 and o_gray=0, regardless of clk. Reset asserts immediately, with no clock required. Release is synchronised by the normal clock edge; the first capture happens at the first rising edge after release.
- Encoding: gray[MSB] = bin[MSB]. For i from 0 to MSB-1, gray[i] = bin[i+1] XOR bin[i]. This is equivalent to bin XOR (bin >> 1), with zero fill. It is purely combinational and has no carries.
- Latency: exactly 1 clock. When i_en=1 at rising edge N, o_gray and o_vld=1 are valid after edge N and are held until edge N+1.
- Throughput: one word per clock. Back-to-back i_en=1 gives continuous o_vld=1 with a new o_gray every cycle.
- i_en=0 at an edge: o_vld goes to 0 on that edge. o_gray holds its last value; it is not cleared.
- No back-pressure and no ready signal. Every enabled input produces exactly one valid output.
- Wrap-around: none internal. Input all-ones encodes to 1 followed by MSB zeros. Input 0 encodes to 0.
- Reset mid-stream: o_vld drops to 0 immediately and o_gray clears to 0. Any word that was in flight is discarded. Normal operation resumes on the first enabled edge after release.
- MSB=0 degenerate case: o_gray equals i_data, delayed by one clock.
- Count property: the number of o_vld cycles equals the number of edges at which i_en=1 while not in reset.

Optional Feature:
- Macro GRAY_DECODE_EN.
- When defined:
  - An extra output o_bin (output, width MSB+1) is present.
  - o_bin is registered in the same stage as o_gray. It holds the binary value recovered from the Gray code: bin[MSB] = gray[MSB], and bin[i] = bin[i+1] XOR gray[i].
  - o_bin therefore equals the accepted i_data. It has the same latency, reset value 0 and hold behaviour as o_gray.
  - This provides a built-in round-trip self-check.
- When not defined: the o_bin port and its logic are absent, and the block is encoder only.

Test Plan:
- Reset: hold rst_n=1 for 100 cycles with random i_en and i_data -> o_vld=0 and o_gray=0 throughout. Assert rst_n asynchronously between edges -> outputs clear without waiting for a clock edge.
- Full sweep (MSB=7): after reset release, drive i_en=1 with i_data = 0,1,...,255 on consecutive clocks, then i_en=0.
  - Required: exactly 256 consecutive o_vld cycles, starting one clock after the first enabled edge.
  - Required: output k equals k XOR (k>>1), e.g. 0->00000000, 1->00000001, 2->00000011, 5->00000111, 128->11000000, 255->10000000.
  - Required: adjacent outputs differ in exactly one bit, including 255->0 (10000000->00000000).
- Gaps: i_en pattern 1,0,0,1 with i_data 3, x, x, 6 -> o_vld 1,0,0,1 delayed one clock. o_gray shows 00000010, held at 00000010 during the gap, then 00000101.
- Reset mid-stream: assert rst_n during a continuous sweep at i_data=100 -> o_vld=0 and o_gray=0 immediately. After release, resuming at 101 gives 01010111 one clock later.
- Parameter: MSB=3 with a sweep of 0..15 -> 16 outputs matching k XOR (k>>1). 15 gives 1000.
- With GRAY_DECODE_EN defined: sweep 0..255 -> o_bin equals the input delayed by one clock for every o_vld cycle.

Source files
------------

// File: rtl/vlg_design.sv
// Binary-to-Gray encoder with one registered output stage and a valid flag.
// Optional GRAY_DECODE_EN adds o_bin, a registered Gray-to-binary round trip of the same word.
module vlg_design #(
    parameter int MSB = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [MSB:0] i_data,
    output logic         o_vld,
`ifdef GRAY_DECODE_EN
    output logic [MSB:0] o_bin,
`endif
    output logic [MSB:0] o_gray
);

    logic [MSB:0] enc;
    logic [MSB:0] gray_d, gray_q;
    logic         vld_d, vld_q;

    // Each Gray bit is the XOR of a binary bit and its upper neighbour; the top bit passes through.
    assign enc[MSB] = i_data[MSB];
    generate
        for (genvar gi = 0; gi < MSB; gi++) begin : g_enc
            assign enc[gi] = i_data[gi+1] ^ i_data[gi];
        end
    endgenerate

    always_comb begin
        vld_d  = i_en;
        gray_d = gray_q;
        if (i_en) begin
            gray_d = enc;
        end
    end

    // rst_n is active-high here despite its name; it clears without waiting for a clock.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_q  <= 1'b0;
            gray_q <= '0;
        end else begin
            vld_q  <= vld_d;
            gray_q <= gray_d;
        end
    end

    assign o_vld  = vld_q;
    assign o_gray = gray_q;

`ifdef GRAY_DECODE_EN
    logic [MSB:0] dec;
    logic [MSB:0] bin_d, bin_q;

    // Decoded bit i is the XOR-reduction of the Gray word from bit i upward.
    generate
        for (genvar gi = 0; gi <= MSB; gi++) begin : g_dec
            assign dec[gi] = ^enc[MSB:gi];
        end
    endgenerate

    always_comb begin
        bin_d = bin_q;
        if (i_en) begin
            bin_d = dec;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bin_q <= '0;
        end else begin
            bin_q <= bin_d;
        end
    end

    assign o_bin = bin_q;
`endif

endmodule

// File: tb/tb_vlg_design.sv
// Directed scoreboard bench for vlg_design: an 8-bit instance and a 4-bit instance.
// Build with GRAY_DECODE_EN defined to also check the o_bin round trip.
module tb_vlg_design;

    logic       clk;
    logic       rst_n;
    logic       i_en;
    logic [7:0] i_data;
    logic       o_vld;
    logic [7:0] o_gray;
    logic       en3;
    logic [3:0] d3;
    logic       vld3;
    logic [3:0] gray3;
`ifdef GRAY_DECODE_EN
    logic [7:0] o_bin;
    logic [3:0] bin3;
`endif

    int n_assert;
    int n_fail;
    int vld_cnt;

    logic [7:0] gq8[$];
    logic [7:0] dq8[$];
    logic [3:0] gq3[$];
    logic [3:0] dq3[$];
    logic [7:0] last8;
    logic [7:0] lastbin8;
    logic [3:0] last3;
    logic [3:0] lastbin3;
    logic [7:0] prev_obs;
    logic       have_prev;
    logic       adj_chk;

    vlg_design #(.MSB(7)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_en),
        .i_data (i_data),
        .o_vld  (o_vld),
`ifdef GRAY_DECODE_EN
        .o_bin  (o_bin),
`endif
        .o_gray (o_gray)
    );

    vlg_design #(.MSB(3)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (en3),
        .i_data (d3),
        .o_vld  (vld3),
`ifdef GRAY_DECODE_EN
        .o_bin  (bin3),
`endif
        .o_gray (gray3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock on the 8-bit instance: drive at negedge, check 1 time unit after the capturing edge.
    task automatic drive8(input logic rst, input logic en, input logic [7:0] d);
        logic       exp_vld;
        logic [7:0] exp_gray;
        logic [7:0] exp_bin;
        @(negedge clk);
        rst_n  = rst;
        i_en   = en;
        i_data = d;
        if (rst) begin
            gq8.delete();
            dq8.delete();
            last8    = 8'h00;
            lastbin8 = 8'h00;
        end else if (en) begin
            gq8.push_back(d ^ (d >> 1));
            dq8.push_back(d);
        end
        @(posedge clk);
        #1;
        exp_vld  = en && !rst;
        exp_gray = last8;
        exp_bin  = lastbin8;
        if (exp_vld && gq8.size() != 0) begin
            exp_gray = gq8.pop_front();
            exp_bin  = dq8.pop_front();
        end
        n_assert++;
        assert (o_vld === exp_vld) else begin
            n_fail++;
            $error("FAIL vld8 observed=%b expected=%b", o_vld, exp_vld);
        end
        chk8("gray8", o_gray, exp_gray);
`ifdef GRAY_DECODE_EN
        chk8("bin8", o_bin, exp_bin);
`endif
        if (o_vld === 1'b1) begin
            vld_cnt++;
            if (adj_chk && have_prev) begin
                n_assert++;
                assert ($countones(o_gray ^ prev_obs) == 1) else begin
                    n_fail++;
                    $error("FAIL adjacent8 observed=%b previous=%b expected one bit change", o_gray, prev_obs);
                end
            end
            prev_obs  = o_gray;
            have_prev = 1'b1;
        end
        last8    = exp_gray;
        lastbin8 = exp_bin;
        $display("tx8 rst=%0d en=%0d data=%0d vld=%0d gray=%b", rst, en, d, o_vld, o_gray);
    endtask

    task automatic drive3(input logic en, input logic [3:0] d);
        logic       exp_vld;
        logic [3:0] exp_gray;
        logic [3:0] exp_bin;
        @(negedge clk);
        en3 = en;
        d3  = d;
        if (en) begin
            gq3.push_back(d ^ (d >> 1));
            dq3.push_back(d);
        end
        @(posedge clk);
        #1;
        exp_vld  = en;
        exp_gray = last3;
        exp_bin  = lastbin3;
        if (exp_vld && gq3.size() != 0) begin
            exp_gray = gq3.pop_front();
            exp_bin  = dq3.pop_front();
        end
        n_assert++;
        assert (vld3 === exp_vld) else begin
            n_fail++;
            $error("FAIL vld3 observed=%b expected=%b", vld3, exp_vld);
        end
        chk4("gray3", gray3, exp_gray);
`ifdef GRAY_DECODE_EN
        chk4("bin3", bin3, exp_bin);
`endif
        last3    = exp_gray;
        lastbin3 = exp_bin;
        $display("tx3 en=%0d data=%0d vld=%0d gray=%b", en, d, vld3, gray3);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        vld_cnt   = 0;
        last8     = 8'h00;
        lastbin8  = 8'h00;
        last3     = 4'h0;
        lastbin3  = 4'h0;
        prev_obs  = 8'h00;
        have_prev = 1'b0;
        adj_chk   = 1'b0;
        rst_n     = 1'b1;
        i_en      = 1'b0;
        i_data    = 8'h00;
        en3       = 1'b0;
        d3        = 4'h0;

        // Held in reset with random activity on both instances.
        for (int i = 0; i < 100; i++) begin
            en3 = 1'($urandom_range(0, 1));
            d3  = 4'($urandom_range(0, 15));
            drive8(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            n_assert++;
            assert (vld3 === 1'b0 && gray3 === 4'h0) else begin
                n_fail++;
                $error("FAIL rst3 observed vld=%b gray=%b expected vld=0 gray=0000", vld3, gray3);
            end
        end
        en3 = 1'b0;

        // Full sweep 0..255, then 0 again to cover the 255->0 transition.
        adj_chk   = 1'b1;
        have_prev = 1'b0;
        vld_cnt   = 0;
        for (int k = 0; k < 256; k++) begin
            drive8(1'b0, 1'b1, 8'(k));
        end
        n_assert++;
        assert (vld_cnt == 256) else begin
            n_fail++;
            $error("FAIL sweep_count observed=%0d expected=256", vld_cnt);
        end
        drive8(1'b0, 1'b1, 8'd0);
        adj_chk = 1'b0;
        drive8(1'b0, 1'b0, 8'd0);

        // Gaps: 1,0,0,1 with data 3,x,x,6.
        drive8(1'b0, 1'b1, 8'd3);
        chk8("gap_first", o_gray, 8'b0000_0010);
        drive8(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        drive8(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        chk8("gap_hold", o_gray, 8'b0000_0010);
        drive8(1'b0, 1'b1, 8'd6);
        chk8("gap_last", o_gray, 8'b0000_0101);
        drive8(1'b0, 1'b0, 8'd0);

        // Reset mid-stream: asserted between edges right after data 100 is shown.
        for (int k = 0; k <= 100; k++) begin
            drive8(1'b0, 1'b1, 8'(k));
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_assert++;
        assert (o_vld === 1'b0 && o_gray === 8'h00) else begin
            n_fail++;
            $error("FAIL async_rst observed vld=%b gray=%b expected vld=0 gray=00000000", o_vld, o_gray);
        end
        drive8(1'b1, 1'b0, 8'd0);
        drive8(1'b1, 1'b0, 8'd0);
        drive8(1'b0, 1'b1, 8'd101);
        chk8("resume101", o_gray, 8'b0101_0111);
        drive8(1'b0, 1'b0, 8'd0);

        // Narrow instance sweep 0..15.
        for (int k = 0; k < 16; k++) begin
            drive3(1'b1, 4'(k));
        end
        chk4("gray3_15", gray3, 4'b1000);
        drive3(1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
